spi_unlock_controller: RTL and testbench
========================================

// Module: spi_unlock_controller
// PURPOSE
//  Session controller behind spi_sequence_detector. Idle in ARMED: detector runs on the shared SPI lines.
//  Detector match opens a control session. Controller then takes sin/sclk, parses [addr][data] byte pairs
//  and issues one-cycle register writes to the shield config block.
//  Session closes on terminator byte, idle timeout or write limit; controller then re-arms the detector.
// PARAMETERS
//  IDLE_TIMEOUT  10000  clk cycles with no sclk edge before session abort (>=2)
//  MAX_WRITES    64     writes per session; the MAX_WRITES-th write closes the session
//  ADDR_W        7      register address width (fixed by byte format; must be 7)
// PORTS
//  clk           in   1  system clock; one clock domain
//  rst           in   1  reset: asynchronous, active-low (0 = reset)
//  sin           in   1  SPI data, already synchronous to clk; sampled MSB-first
//  sclk          in   1  SPI clock, already synchronous to clk; data sampled on its rising edge
//  match         in   1  one-cycle pulse from spi_sequence_detector
//  det_rst       out  1  active-high reset to spi_sequence_detector
//  session       out  1  1 while a control session is open
//  reg_wr_en     out  1  one-cycle write strobe
//  reg_addr      out  7  write address, valid with reg_wr_en
//  reg_wdata     out  8  write data, valid with reg_wr_en
//  unlock_count  out  8  count of accepted matches, saturates at 255
// BEHAVIOUR
//  - Reset (rst=0): state=ARMED, det_rst=1 (combinational OR with ~rst), session=0, reg_wr_en=0,
//    reg_addr=0, reg_wdata=0, unlock_count=0, bit/byte/timeout/write counters=0, sclk_q=0.
//  - Edge detect: sclk_q registered every clk; rise = sclk & ~sclk_q. No other synchroniser.
//  - States: ARMED, ADDR, DATA, WRITE.
//  - ARMED: det_rst=0, session=0.
//      match=1 -> ADDR next cycle. bit counter and write counter cleared, timeout loaded,
//      unlock_count+1 (saturating).
//  - ADDR, DATA, WRITE: det_rst=1, session=1. match is ignored.
//  - Bit shift: on rise, shift sin in MSB-first. The 8th rise completes a byte in the same cycle
//    (byte = {shreg[6:0], sin}); the bit counter wraps to 0.
//  - ADDR, byte done:
//      0x00          -> ARMED (terminator)
//      bit7=1        -> latch addr=byte[6:0], go to DATA
//      other values  -> discard byte, stay in ADDR
//  - DATA, byte done: latch wdata, go to WRITE.
//  - WRITE: lasts exactly one cycle.
//      reg_wr_en=1; reg_addr/reg_wdata registered and stable since entry.
//      write counter +1. Next state ADDR, or ARMED if count reaches MAX_WRITES.
//      A rise during WRITE is still shifted (no bit lost).
//  - Latency: final data bit rise at cycle N -> reg_wr_en high at cycle N+1.
//  - Timeout: down-counter reloaded to IDLE_TIMEOUT on every rise and on session entry; decrements
//    otherwise while session=1. At 0 -> ARMED: partial byte and pending addr dropped, no write.
//  - Simultaneous events:
//      rise and expiry in same cycle -> rise wins (reload, no abort)
//      byte done with terminator     -> terminator wins over timeout
//  - Return to ARMED: det_rst falls on the following cycle, so the detector starts from a clean history.
//  - reg_addr/reg_wdata hold their last value when reg_wr_en=0. reg_wr_en never high in ARMED.
//  - rst asserted mid-session: immediate abort to reset values. No write issued, even if WRITE was pending.
// STRUCTURE
//  - Shared package spi_ctrl_pkg: state encoding, TERMINATOR=8'h00, WRITE_FLAG bit index 7, byte width 8.
//  - One sub-module: spi_byte_receiver (sclk edge detect, shift register, bit counter, byte_valid pulse,
//    clear input). The FSM, timeout, write counter and outputs live in the top.
// TESTING (bench: spi_slave_tester driving sin/sclk, period 100, real spi_sequence_detector on match)
//  1. Key 92 9d 9a 9b 29 35 a2 65, then 85 3c, then 00
//     -> one reg_wr_en: addr=0x05, data=0x3c, one cycle after last data rise.
//        session falls after the 00 byte; unlock_count=1; det_rst low afterwards.
//  2. Key, 81 11, 82 22, then idle IDLE_TIMEOUT+10 clks
//     -> two writes (01/11, 02/22), then session=0 exactly IDLE_TIMEOUT clks after last rise.
//  3. Key, 05 (no write flag), 83 44, 00 -> 05 discarded; single write addr=0x03 data=0x44.
//  4. Key, 84, 4 bits of data, then rst=0 for 20 ns
//     -> no reg_wr_en; all outputs at reset values; a second key re-opens the session.
//  5. Key, then MAX_WRITES pairs 80+i/i
//     -> MAX_WRITES strobes; session=0 right after the last one; further bytes ignored until the next key.
//  6. 20 random bytes with no key -> session=0 throughout, reg_wr_en never high, unlock_count=0.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI unlock session controller: session states,
// byte-format constants and the saturating counter helper.
package spi_ctrl_pkg;

  localparam int         BYTE_W     = 8;
  localparam int         WRITE_FLAG = 7;
  localparam logic [7:0] TERMINATOR = 8'h00;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_byte_receiver.sv
// Rising-edge detector on the (already synchronous) sclk plus an MSB-first
// shift register that flags each completed byte in the cycle of its 8th rise.
module spi_byte_receiver
  import spi_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sin,
  input  logic              i_sclk,
  input  logic              i_clr,
  output logic              o_rise,
  output logic              o_byte_valid,
  output logic [BYTE_W-1:0] o_byte
);

  logic              r_sclk_q;
  logic [BYTE_W-2:0] r_shreg;
  logic [2:0]        r_bitcnt;

  assign o_rise       = i_sclk & ~r_sclk_q;
  assign o_byte_valid = o_rise & ~i_clr & (r_bitcnt == 3'd7);
  assign o_byte       = {r_shreg, i_sin};

  // Clear wins over a coincident rise so a new session always starts on bit 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_q <= 1'b0;
      r_shreg  <= '0;
      r_bitcnt <= 3'd0;
    end else begin
      r_sclk_q <= i_sclk;
      if (i_clr) begin
        r_bitcnt <= 3'd0;
      end else if (o_rise) begin
        r_shreg  <= o_byte[BYTE_W-2:0];
        r_bitcnt <= r_bitcnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/spi_unlock_controller.sv
// Session controller: opens on a detector match, turns [addr][data] byte pairs
// into one-cycle register writes, and re-arms the detector when the session ends.
module spi_unlock_controller
  import spi_ctrl_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 10000,
  parameter int MAX_WRITES   = 64,
  parameter int ADDR_W       = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sclk,
  input  logic              match,
  output logic              det_rst,
  output logic              session,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic [7:0]        unlock_count
);

  localparam int TMO_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int WCNT_W = $clog2(MAX_WRITES + 1);

  state_t            r_state, w_next;
  logic [TMO_W-1:0]  r_tmo;
  logic [WCNT_W-1:0] r_wcnt;
  logic [7:0]        r_unlock;
  logic [ADDR_W-1:0] r_addr_pend;

  logic              w_clr, w_rise, w_byte_valid, w_expire, w_last_write;
  logic [BYTE_W-1:0] w_byte;

  spi_byte_receiver u_rx (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_sin        (sin),
    .i_sclk       (sclk),
    .i_clr        (w_clr),
    .o_rise       (w_rise),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte)
  );

  assign w_clr        = (r_state == ST_ARMED);
  // Abort edge lands IDLE_TIMEOUT cycles after the last rise cycle; a rise always reloads instead.
  assign w_expire     = (r_state != ST_ARMED) && !w_rise && (r_tmo <= TMO_W'(2));
  assign w_last_write = (r_wcnt == WCNT_W'(MAX_WRITES - 1));
  assign unlock_count = r_unlock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_ARMED;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ARMED: if (match) w_next = ST_ADDR;
      ST_ADDR: begin
        if (w_byte_valid) begin
          if (w_byte == TERMINATOR)     w_next = ST_ARMED;
          else if (w_byte[WRITE_FLAG])  w_next = ST_DATA;
        end else if (w_expire) begin
          w_next = ST_ARMED;
        end
      end
      ST_DATA: begin
        if (w_byte_valid)  w_next = ST_WRITE;
        else if (w_expire) w_next = ST_ARMED;
      end
      ST_WRITE: w_next = (w_last_write || w_expire) ? ST_ARMED : ST_ADDR;
      default:  w_next = ST_ARMED;
    endcase
  end

  always_comb begin
    session   = (r_state != ST_ARMED);
    det_rst   = ~rst | session;
    reg_wr_en = (r_state == ST_WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo       <= '0;
      r_wcnt      <= '0;
      r_unlock    <= 8'd0;
      r_addr_pend <= '0;
      reg_addr    <= '0;
      reg_wdata   <= 8'd0;
    end else begin
      if (r_state == ST_ARMED) begin
        if (match) begin
          r_wcnt   <= '0;
          r_tmo    <= TMO_W'(IDLE_TIMEOUT);
          r_unlock <= sat_inc8(r_unlock);
        end
      end else if (w_rise) begin
        r_tmo <= TMO_W'(IDLE_TIMEOUT);
      end else begin
        r_tmo <= r_tmo - TMO_W'(1);
      end
      if (r_state == ST_ADDR && w_byte_valid && w_byte[WRITE_FLAG])
        r_addr_pend <= w_byte[ADDR_W-1:0];
      // Outputs change only on entry to WRITE so they hold between strobes.
      if (r_state == ST_DATA && w_byte_valid) begin
        reg_addr  <= r_addr_pend;
        reg_wdata <= w_byte;
      end
      if (r_state == ST_WRITE)
        r_wcnt <= r_wcnt + WCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_unlock_controller.sv
// Directed bench for spi_unlock_controller: a table of session bytes with
// expected outputs, plus hand-written sequences for timeout, reset, limit and saturation.
module tb_spi_unlock_controller;

  localparam int T  = 40;
  localparam int MW = 4;

  logic       clk = 1'b0, rst = 1'b0, sin = 1'b0, sclk = 1'b0, match = 1'b0;
  logic       det_rst, session, reg_wr_en;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, unlock_count;

  spi_unlock_controller #(.IDLE_TIMEOUT(T), .MAX_WRITES(MW), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sclk(sclk), .match(match),
    .det_rst(det_rst), .session(session), .reg_wr_en(reg_wr_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .unlock_count(unlock_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int wr_events = 0, last_wr_cyc = -100, last_rise_set = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_events++;
      last_wr_cyc = cyc;
      chk("wr_en_outside_session", int'(session), 1);
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk); sclk = 1'b0; sin = b;
    @(negedge clk);
    @(negedge clk); sclk = 1'b1; last_rise_set = cyc;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic open_session();
    @(negedge clk); match = 1'b1;
    @(negedge clk); match = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    int         exp_wr;
    logic [6:0] exp_a;
    logic [7:0] exp_d;
    logic       exp_sess;
    logic       chk_lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c, found;
    tbl[0] = '{8'h85, 0, 7'h00, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h3c, 1, 7'h05, 8'h3c, 1'b1, 1'b1};
    tbl[2] = '{8'h05, 1, 7'h05, 8'h3c, 1'b1, 1'b0};
    tbl[3] = '{8'h83, 1, 7'h05, 8'h3c, 1'b1, 1'b0};
    tbl[4] = '{8'h44, 2, 7'h03, 8'h44, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 2, 7'h03, 8'h44, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_det_rst", int'(det_rst), 1);
    chk("rst_session", int'(session), 0);
    chk("rst_wr_en", int'(reg_wr_en), 0);
    chk("rst_addr", int'(reg_addr), 0);
    chk("rst_wdata", int'(reg_wdata), 0);
    chk("rst_unlock", int'(unlock_count), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("armed_det_rst", int'(det_rst), 0);

    // Table-driven session: write, discarded byte, write, terminator
    base = wr_events;
    open_session();
    chk("a_det_rst_in_session", int'(det_rst), 1);
    for (int i = 0; i < 6; i++) begin
      send_byte(tbl[i].b);
      chk($sformatf("a%0d_writes", i), wr_events - base, tbl[i].exp_wr);
      chk($sformatf("a%0d_addr", i), int'(reg_addr), int'(tbl[i].exp_a));
      chk($sformatf("a%0d_wdata", i), int'(reg_wdata), int'(tbl[i].exp_d));
      chk($sformatf("a%0d_session", i), int'(session), int'(tbl[i].exp_sess));
      if (tbl[i].chk_lat) chk($sformatf("a%0d_latency", i), last_wr_cyc - last_rise_set, 1);
    end
    chk("a_det_rst_after", int'(det_rst), 0);
    chk("a_unlock", int'(unlock_count), 1);

    // Two writes then idle timeout
    base = wr_events;
    open_session();
    send_byte(8'h81); send_byte(8'h11);
    chk("b_addr1", int'(reg_addr), 'h01);
    chk("b_data1", int'(reg_wdata), 'h11);
    send_byte(8'h82); send_byte(8'h22);
    chk("b_writes", wr_events - base, 2);
    chk("b_addr2", int'(reg_addr), 'h02);
    chk("b_data2", int'(reg_wdata), 'h22);
    c = last_rise_set;
    found = -1;
    for (int k = 0; k < 3 * T && found < 0; k++) begin
      @(negedge clk);
      if (!session) found = cyc;
    end
    chk("b_timeout_cycles", found - c, T);
    chk("b_det_rst_after", int'(det_rst), 0);
    chk("b_unlock", int'(unlock_count), 2);

    // Reset in the middle of a data byte
    base = wr_events;
    open_session();
    send_byte(8'h84);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("c_det_rst", int'(det_rst), 1);
    chk("c_session", int'(session), 0);
    chk("c_wr_en", int'(reg_wr_en), 0);
    chk("c_addr", int'(reg_addr), 0);
    chk("c_wdata", int'(reg_wdata), 0);
    chk("c_unlock", int'(unlock_count), 0);
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("c_no_write", wr_events - base, 0);
    open_session();
    chk("c_reopen_session", int'(session), 1);
    open_session();
    chk("c_match_ignored", int'(unlock_count), 1);
    send_byte(8'h86); send_byte(8'h77);
    chk("c_writes", wr_events - base, 1);
    chk("c_addr2", int'(reg_addr), 'h06);
    chk("c_wdata2", int'(reg_wdata), 'h77);
    send_byte(8'h00);
    chk("c_closed", int'(session), 0);

    // Write limit closes the session
    base = wr_events;
    open_session();
    for (int i = 0; i < MW; i++) begin
      send_byte(8'h80 + 8'(i));
      send_byte(8'(i));
    end
    chk("d_writes", wr_events - base, MW);
    chk("d_addr", int'(reg_addr), MW - 1);
    chk("d_wdata", int'(reg_wdata), MW - 1);
    chk("d_session", int'(session), 0);
    send_byte(8'h85); send_byte(8'h3c);
    chk("d_ignored_writes", wr_events - base, MW);
    chk("d_ignored_session", int'(session), 0);
    chk("d_unlock", int'(unlock_count), 2);

    // Bytes with no key
    base = wr_events;
    for (int i = 0; i < 20; i++) begin
      send_byte(8'($urandom_range(255)));
      chk($sformatf("e%0d_session", i), int'(session), 0);
    end
    chk("e_writes", wr_events - base, 0);
    chk("e_unlock", int'(unlock_count), 2);

    // unlock_count saturation: 2 + 255 matches must stop at 255
    for (int i = 0; i < 255; i++) begin
      open_session();
      send_byte(8'h00);
    end
    chk("f_unlock_sat", int'(unlock_count), 255);
    chk("f_session", int'(session), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
